// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory stage.
//   - lsu_state_e : stage FSM states (IDLE, REQ, RESP, WB)
//   - lsu_size_e  : access size (BYTE, HALF, WORD)
//   - lsu_op_t    : decoded access (size, unsigned-load flag, store flag)
//   - BE_*        : byte-enable patterns before shifting to the addressed lane
//   - count_en / decode_op : helpers over the 8-bit enable vector, ordered
//     {lb, lh, lw, lbu, lhu, sb, sh, sw} (bit 7 down to bit 0).
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef struct packed {
        lsu_size_e size;
        logic      is_unsigned;
        logic      is_store;
    } lsu_op_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Number of memory-op enables asserted; anything but 0 or 1 is illegal.
    function automatic logic [3:0] count_en(input logic [7:0] en);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, en[i]};
        end
        return cnt;
    endfunction

    // Size / signedness / direction of a one-hot enable vector.
    function automatic lsu_op_t decode_op(input logic [7:0] en);
        lsu_op_t op;
        op.is_store    = en[2] | en[1] | en[0];
        op.is_unsigned = en[4] | en[3];
        if (en[7] | en[4] | en[2]) begin
            op.size = SZ_BYTE;
        end else if (en[6] | en[3] | en[1]) begin
            op.size = SZ_HALF;
        end else begin
            op.size = SZ_WORD;
        end
        return op;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword out of a 32-bit load
// word and sign- or zero-extends it.
//   rdata       in  32  raw memory word
//   offset      in  2   low address bits captured with the request
//   size        in      access size
//   is_unsigned in  1   1 = zero-extend (LBU/LHU)
//   data        out 32  extended load value
// Halfword selection only looks at offset[1]; an odd halfword address reads
// the enclosing aligned halfword.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_WORD: data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory/writeback stage after the ALU. Loads and stores run a
// req/gnt/rvalid transaction using alu_out as the effective address; all
// other instructions pass alu_out through to writeback. One op in flight.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake (in_ready high only in IDLE)
//   alu_out, store_data, rd_in, lb_en..sw_en   operands and one-hot enables
//   mem_req/we/addr/be/wdata  memory request (held stable until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata            memory grant and load response
//   wb_valid/we/rd/data       one-cycle writeback pulse
//   misalign_trap             one-cycle pulse alongside wb_valid
//
// Build option LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses skip
// the memory transaction and raise misalign_trap with wb_we = 0. Without it
// misalign_trap is tied low and the low address bits are ignored.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rd_in,
    input  logic              lb_en,
    input  logic              lh_en,
    input  logic              lw_en,
    input  logic              lbu_en,
    input  logic              lhu_en,
    input  logic              sb_en,
    input  logic              sh_en,
    input  logic              sw_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_trap
);

    logic [7:0]        en_s;
    logic [3:0]        n_en_s;
    lsu_op_t           op_s;
    logic              accept_s;
    logic [3:0]        be_s;
    logic [DATA_W-1:0] lanes_s;
    logic [DATA_W-1:0] wdata_s;
    logic              misal_s;
    logic [31:0]       ld_s;

    lsu_state_e        state_r;
    logic [4:0]        rd_r;
    logic [1:0]        off_r;
    lsu_size_e         size_r;
    logic              uns_r;
    logic              store_r;
    logic              we_pend_r;
    logic [DATA_W-1:0] res_r;

    assign en_s     = {lb_en, lh_en, lw_en, lbu_en, lhu_en, sb_en, sh_en, sw_en};
    assign n_en_s   = count_en(en_s);
    assign op_s     = decode_op(en_s);
    assign accept_s = in_valid && in_ready;

    // Byte enables and lane-replicated store data for the incoming op.
    always_comb begin
        be_s    = BE_WORD;
        lanes_s = store_data;
        case (op_s.size)
            SZ_BYTE: begin
                be_s    = BE_BYTE0 << alu_out[1:0];
                lanes_s = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be_s    = alu_out[1] ? BE_HALF_HI : BE_HALF_LO;
                lanes_s = {2{store_data[15:0]}};
            end
            SZ_WORD: begin
                be_s    = BE_WORD;
                lanes_s = store_data;
            end
            default: begin
                be_s    = BE_WORD;
                lanes_s = store_data;
            end
        endcase
    end

    // Loads still present byte enables but never write data.
    assign wdata_s = op_s.is_store ? lanes_s : {DATA_W{1'b0}};

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfword needs addr[0] = 0, word needs addr[1:0] = 0.
    always_comb begin
        misal_s = 1'b0;
        if (op_s.size == SZ_HALF) begin
            misal_s = alu_out[0];
        end else if (op_s.size == SZ_WORD) begin
            misal_s = (alu_out[1:0] != 2'b00);
        end else begin
            misal_s = 1'b0;
        end
    end
`else
    assign misal_s = 1'b0;
`endif

    lsu_load_align u_load_align (
        .rdata       (mem_rdata),
        .offset      (off_r),
        .size        (size_r),
        .is_unsigned (uns_r),
        .data        (ld_s)
    );

    // Stage FSM with all memory and writeback outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_be    <= 4'b0000;
            mem_wdata <= {DATA_W{1'b0}};
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= {DATA_W{1'b0}};
            rd_r      <= 5'd0;
            off_r     <= 2'b00;
            size_r    <= SZ_BYTE;
            uns_r     <= 1'b0;
            store_r   <= 1'b0;
            we_pend_r <= 1'b0;
            res_r     <= {DATA_W{1'b0}};
        end else begin
            wb_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rd_r    <= rd_in;
                        off_r   <= alu_out[1:0];
                        size_r  <= op_s.size;
                        uns_r   <= op_s.is_unsigned;
                        store_r <= op_s.is_store;
                        if (n_en_s == 4'd0) begin
                            res_r     <= alu_out;
                            we_pend_r <= (rd_in != 5'd0);
                            state_r   <= ST_WB;
                            in_ready  <= 1'b0;
                        end else if (n_en_s == 4'd1) begin
                            res_r    <= {DATA_W{1'b0}};
                            in_ready <= 1'b0;
                            if (misal_s) begin
                                we_pend_r <= 1'b0;
                                state_r   <= ST_WB;
                            end else begin
                                mem_req   <= 1'b1;
                                mem_we    <= op_s.is_store;
                                mem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
                                mem_be    <= be_s;
                                mem_wdata <= wdata_s;
                                we_pend_r <= !op_s.is_store && (rd_in != 5'd0);
                                state_r   <= ST_REQ;
                            end
                        end else begin
                            // Conflicting enables: the op is dropped.
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= store_r ? ST_WB : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rvalid) begin
                        res_r   <= ld_s;
                        state_r <= ST_WB;
                    end
                end
                ST_WB: begin
                    wb_valid <= 1'b1;
                    wb_we    <= we_pend_r;
                    wb_rd    <= rd_r;
                    wb_data  <= res_r;
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b1;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic trap_pend_r;

    // Trap flag captured at accept and pulsed together with wb_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_pend_r   <= 1'b0;
            misalign_trap <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && accept_s) begin
                trap_pend_r <= (n_en_s == 4'd1) && misal_s;
            end else begin
                trap_pend_r <= trap_pend_r;
            end
            misalign_trap <= (state_r == ST_WB) && trap_pend_r;
        end
    end
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus pushes expected memory
// requests, memory responses and writebacks into queues; a memory responder
// and a monitor consume them independently of the stimulus.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        lb_en, lh_en, lw_en, lbu_en, lhu_en, sb_en, sh_en, sw_en;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_trap;

    always #5 clk = ~clk;

    lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .store_data(store_data), .rd_in(rd_in),
        .lb_en(lb_en), .lh_en(lh_en), .lw_en(lw_en), .lbu_en(lbu_en), .lhu_en(lhu_en),
        .sb_en(sb_en), .sh_en(sh_en), .sw_en(sw_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign_trap(misalign_trap)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        logic        trap;
        int          cyc;
    } wb_t;

    typedef struct {
        int          gd;
        int          rdl;
        logic [31:0] rdata;
        logic        is_load;
    } resp_t;

    mreq_t mq[$];
    wb_t   wq[$];
    resp_t rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_en(input logic [7:0] v);
        {lb_en, lh_en, lw_en, lbu_en, lhu_en, sb_en, sh_en, sw_en} = v;
    endtask

    // ---- reference model: ops 0..7 = LB LH LW LBU LHU SB SH SW, 8 = none, 9 = conflicting
    function automatic int size_of(input int op);
        case (op)
            0, 3, 5: return 0;
            1, 4, 6: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input int op, input int lane, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lane)) & 32'h0000_00FF;
        h = (lane >= 2) ? (w >> 16) : (w & 32'h0000_FFFF);
        case (op)
            0:       return (b >= 32'd128) ? b - 32'd256 : b;
            3:       return b;
            1:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            4:       return h;
            default: return w;
        endcase
    endfunction

    function automatic wb_t mk_wb(input logic [4:0] rd, input logic we, input logic [31:0] d,
                                  input logic chk, input logic trap, input int c);
        wb_t w;
        w.rd = rd; w.we = we; w.data = d; w.chk_data = chk; w.trap = trap; w.cyc = c;
        return w;
    endfunction

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input int gd, input int rdl,
                         input logic [31:0] rdata, input bit exp_wb);
        int          guard;
        int          c0;
        int          sz;
        int          lane;
        int          i;
        int          j;
        logic [7:0]  en;
        logic        mis;
        mreq_t       m;
        resp_t       r;
        wb_t         w;
        guard = 0;
        @(negedge clk);
        // While busy, throw garbage at the input; it must be ignored.
        while (in_ready !== 1'b1 && guard < 100) begin
            in_valid   = 1'($urandom_range(1, 0));
            alu_out    = $urandom;
            store_data = $urandom;
            rd_in      = 5'($urandom);
            set_en(8'($urandom));
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        en = 8'h00;
        if (op < 8) begin
            en = 8'h80 >> op;
        end else if (op == 9) begin
            i  = $urandom_range(7, 0);
            j  = (i + 1 + $urandom_range(6, 0)) % 8;
            en = (8'h01 << i) | (8'h01 << j);
        end
        c0         = cyc;
        alu_out    = a;
        store_data = sd;
        rd_in      = rd;
        set_en(en);
        in_valid   = 1'b1;
        lane = int'(a[1:0]);
        sz   = size_of(op);
        mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (sz == 1 && (lane % 2) == 1) || (sz == 2 && lane != 0);
`endif
        if (op == 8) begin
            wq.push_back(mk_wb(rd, rd != 5'd0, a, 1'b1, 1'b0, c0 + 2));
        end else if (op < 8) begin
            if (mis) begin
                if (exp_wb) wq.push_back(mk_wb(rd, 1'b0, 32'h0, 1'b0, 1'b1, c0 + 2));
            end else begin
                m.we   = (op >= 5);
                m.addr = a - 32'(lane);
                if (sz == 0)      m.be = 4'(1 << lane);
                else if (sz == 1) m.be = (lane >= 2) ? 4'd12 : 4'd3;
                else              m.be = 4'd15;
                if (op < 5)       m.wdata = 32'h0;
                else if (sz == 0) m.wdata = (sd & 32'h0000_00FF) * 32'h0101_0101;
                else if (sz == 1) m.wdata = (sd & 32'h0000_FFFF) * 32'h0001_0001;
                else              m.wdata = sd;
                mq.push_back(m);
                r.gd = gd; r.rdl = rdl; r.rdata = rdata; r.is_load = (op < 5);
                rq.push_back(r);
                if (op >= 5) w = mk_wb(rd, 1'b0, 32'h0, 1'b0, 1'b0, c0 + 3 + gd);
                else         w = mk_wb(rd, rd != 5'd0, load_val(op, lane, rdata), 1'b1, 1'b0, c0 + 4 + gd + rdl);
                if (exp_wb) wq.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        set_en(8'h00);
    endtask

    // Memory responder: grants after gd REQ cycles, returns data after rdl
    // further cycles, and sprinkles stray gnt/rvalid where they must be ignored.
    initial begin : responder
        int    ph;
        int    cnt;
        resp_t cur;
        ph = 0; cnt = 0;
        cur.gd = 0; cur.rdl = 0; cur.rdata = 32'h0; cur.is_load = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (ph == 0 && mem_req === 1'b1) begin
                if (rq.size() > 0) cur = rq.pop_front();
                ph  = 1;
                cnt = 0;
            end
            if (ph == 0) begin
                mem_gnt    = ($urandom_range(3, 0) == 0);
                mem_rvalid = ($urandom_range(3, 0) == 0);
            end else if (ph == 1) begin
                if (cnt == cur.gd) begin
                    mem_gnt = 1'b1;
                    ph      = cur.is_load ? 2 : 0;
                    cnt     = 0;
                end else begin
                    cnt++;
                    mem_rvalid = ($urandom_range(2, 0) == 0);
                end
            end else begin
                if (cnt == cur.rdl) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = cur.rdata;
                    ph         = 0;
                end else begin
                    cnt++;
                    mem_gnt = ($urandom_range(2, 0) == 0);
                end
            end
        end
    end

    // Monitor: checks each new request, request stability and every writeback.
    initial begin : monitor
        bit    req_seen;
        mreq_t cur;
        wb_t   e;
        req_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (mem_req === 1'b1) begin
                    check("in_ready_busy", 32'(in_ready), 32'd0);
                    if (!req_seen) begin
                        if (mq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_mem_req actual addr=0x%08h required none", mem_addr);
                            cur.we = mem_we; cur.addr = mem_addr; cur.be = mem_be; cur.wdata = mem_wdata;
                        end else begin
                            cur = mq.pop_front();
                            check("mem_we", 32'(mem_we), 32'(cur.we));
                            check("mem_addr", mem_addr, cur.addr);
                            check("mem_be", 32'(mem_be), 32'(cur.be));
                            check("mem_wdata", mem_wdata, cur.wdata);
                        end
                        req_seen = 1'b1;
                    end else begin
                        check("req_stable_addr", mem_addr, cur.addr);
                        check("req_stable_be", 32'(mem_be), 32'(cur.be));
                        check("req_stable_wdata", mem_wdata, cur.wdata);
                        check("req_stable_we", 32'(mem_we), 32'(cur.we));
                    end
                end else begin
                    req_seen = 1'b0;
                end
                if (wb_valid === 1'b1) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wb actual data=0x%08h required no writeback", wb_data);
                    end else begin
                        e = wq.pop_front();
                        check("wb_cycle", 32'(cyc), 32'(e.cyc));
                        check("wb_rd", 32'(wb_rd), 32'(e.rd));
                        check("wb_we", 32'(wb_we), 32'(e.we));
                        check("misalign_trap", 32'(misalign_trap), 32'(e.trap));
                        if (e.chk_data) check("wb_data", wb_data, e.data);
                    end
                end else if (misalign_trap !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL trap_without_wb actual=1 required=0");
                end
            end
        end
    end

    initial begin : stimulus
        int          op;
        logic [31:0] a;
        rst = 1'b1; in_valid = 1'b0; alu_out = 32'h0; store_data = 32'h0; rd_in = 5'd0;
        set_en(8'h00);
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_trap", 32'(misalign_trap), 32'd0);
        rst = 1'b0;

        // Directed cases.
        issue(5, 32'h0000_1003, 32'h0000_00AB, 5'd3, 0, 0, 32'h0, 1'b1);        // SB
        issue(0, 32'h0000_2001, 32'h0, 5'd7, 0, 0, 32'h1234_80FF, 1'b1);        // LB
        issue(3, 32'h0000_2001, 32'h0, 5'd7, 0, 0, 32'h1234_80FF, 1'b1);        // LBU
        issue(8, 32'hDEAD_BEEF, 32'h0, 5'd5, 0, 0, 32'h0, 1'b1);                // pass, rd=5
        issue(8, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0, 32'h0, 1'b1);                // pass, rd=0
        issue(6, 32'h0000_0102, 32'h0000_BEEF, 5'd4, 3, 0, 32'h0, 1'b1);        // SH, grant stall
        issue(2, 32'h0000_1002, 32'h0, 5'd8, 0, 1, 32'h89AB_CDEF, 1'b1);        // misaligned LW
        issue(9, 32'h0000_4000, 32'h0, 5'd6, 0, 0, 32'h0, 1'b1);                // conflicting enables
        check("drop_in_ready", 32'(in_ready), 32'd1);

        // Reset while waiting for load data; the late rvalid must be ignored.
        issue(2, 32'h0000_3000, 32'h0, 5'd9, 0, 4, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        repeat (8) @(negedge clk);
        check("rst_mid_idle", 32'(in_ready), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(9, 0);
            a  = $urandom;
            if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
            issue(op, a, $urandom, 5'($urandom), $urandom_range(3, 0),
                  $urandom_range(3, 0), $urandom, 1'b1);
        end

        for (int k = 0; k < 200 && wq.size() > 0; k++) @(negedge clk);
        check("wb_queue_drained", 32'(wq.size()), 32'd0);
        check("mem_queue_drained", 32'(mq.size()), 32'd0);
        check("resp_queue_drained", 32'(rq.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
